// File: rtl/lut_config_sequencer.sv
// Runtime-reconfigurable N-input LUT with a serial config loader.
// Shadow load with atomic commit; registered 1-deep lookup path.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   cfg_start           begin or restart a table load
//   cfg_valid/cfg_bit   serial table bits, index 0 first
//   cfg_ready           high while loading (bits accepted)
//   cfg_done            one-cycle pulse after a commit
//   busy                high while loading
//   in_valid/in_ready/I lookup request handshake and index
//   out_valid/out_ready/O lookup result handshake and data
//   table_q             active table readback
module lut_config_sequencer #(
  parameter int N = 2,
  parameter logic [2**N-1:0] INIT = 4'h5
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           cfg_start,
  input  logic           cfg_valid,
  input  logic           cfg_bit,
  output logic           cfg_ready,
  output logic           cfg_done,
  output logic           busy,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   I,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           O,
  output logic [2**N-1:0] table_q
);

  localparam int W  = 2**N;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {
    S_IDLE,
    S_LOAD
  } state_t;

  state_t          state;
  logic [W-1:0]    active;
  logic [W-1:0]    shadow;
  logic [W-1:0]    shadow_nxt;
  logic [CW-1:0]   cnt;
  logic            accept;

  assign shadow_nxt = {cfg_bit, shadow[W-1:1]};
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign table_q    = active;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      active    <= INIT;
      shadow    <= '0;
      cnt       <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cfg_start) begin
            state     <= S_LOAD;
            cnt       <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          // A restart drops whatever bit shows up with it.
          if (cfg_start) begin
            cnt <= '0;
          end else if (cfg_valid) begin
            shadow <= shadow_nxt;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              active    <= shadow_nxt;
              state     <= S_IDLE;
              cfg_ready <= 1'b0;
              busy      <= 1'b0;
              cfg_done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Lookup reads active before any same-cycle commit lands.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid <= 1'b0;
      O         <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      O         <= active[I];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
